// File: rtl/eram_pkg.sv
// eram_pkg: shared types and widths for the external SRAM path.
// Used by the arbiter and the pin stage.
package eram_pkg;

    localparam int ERAM_AW = 15;
    localparam int ERAM_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_WAIT
    } eram_state_t;

endpackage

// File: rtl/eram_arbiter_if.sv
// eram_arbiter_if: request/ack/read-return bundle of both clients.
// master = client side, slave = arbiter side.
interface eram_arbiter_if
    import eram_pkg::*;
#(
    parameter int AW = ERAM_AW,
    parameter int DW = ERAM_DW
);

    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic [DW-1:0] a_rdata;
    logic          a_rvalid;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    logic          b_rvalid;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata, a_rvalid,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata, b_rvalid
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata, a_rvalid,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata, b_rvalid
    );

endinterface

// File: rtl/eram_rr_arb.sv
// eram_rr_arb: two-input round-robin arbiter.
// grant: 0 = client A, 1 = client B.
module eram_rr_arb
    import eram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic grant,
    output logic grant_valid
);

    logic ptr_q;

    assign grant_valid = req_a | req_b;
    assign grant = (req_a && req_b) ? ptr_q : req_b;

    // pointer names the client not served last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (take) begin
            ptr_q <= ~grant;
        end
    end

endmodule

// File: rtl/eram_arbiter.sv
// eram_arbiter: two-client arbiter and SRAM access sequencer.
// Address moves only at the grant edge; we never overlaps it.
module eram_arbiter
    import eram_pkg::*;
#(
    parameter int AW        = ERAM_AW,
    parameter int DW        = ERAM_DW,
    parameter int WR_CYCLES = 2,
    parameter int RD_WAIT   = 2
) (
    input  logic          c25,
    input  logic          reset_n,
    eram_arbiter_if.slave bus,
    output logic [AW-1:0] address,
    output logic [DW-1:0] datain,
    output logic          we,
    input  logic [DW-1:0] dataout
);

    localparam int CW = 4;

    eram_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          gnt_b_q, gnt_b_d;
    logic          we_q, we_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [DW-1:0] a_rdata_q, b_rdata_q;
    logic          a_pend_q, b_pend_q;
    logic          a_rvalid_q, b_rvalid_q;
    logic          cap;
    logic          take;
    logic          gnt;
    logic          gnt_valid;

    eram_rr_arb u_arb (
        .clk         (c25),
        .rst_n       (reset_n),
        .req_a       (bus.a_req),
        .req_b       (bus.b_req),
        .take        (take),
        .grant       (gnt),
        .grant_valid (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_b_d = gnt_b_q;
        we_d    = 1'b0;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        cap     = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    take    = 1'b1;
                    gnt_b_d = gnt;
                    a_ack_d = ~gnt;
                    b_ack_d = gnt;
                    addr_d  = gnt ? bus.b_addr : bus.a_addr;
                    wdata_d = gnt ? bus.b_wdata : bus.a_wdata;
                    if (gnt ? bus.b_we : bus.a_we) begin
                        state_d = ST_WR_SETUP;
                    end else begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = CW'(RD_WAIT - 1);
                    end
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = CW'(WR_CYCLES - 1);
                we_d    = 1'b1;
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    we_d  = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    cap     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_b_q    <= 1'b0;
            we_q       <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_b_q    <= gnt_b_d;
            we_q       <= we_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            // data lands first, valid strobe follows one cycle later
            if (cap && !gnt_b_q) a_rdata_q <= dataout;
            if (cap && gnt_b_q)  b_rdata_q <= dataout;
            a_pend_q   <= cap & ~gnt_b_q;
            b_pend_q   <= cap & gnt_b_q;
            a_rvalid_q <= a_pend_q;
            b_rvalid_q <= b_pend_q;
        end
    end

    assign address      = addr_q;
    assign datain       = wdata_q;
    assign we           = we_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_eram_arbiter.sv
// tb_eram_arbiter: directed bench for eram_arbiter, default build
// plus a WR_CYCLES=1 / RD_WAIT=4 build, each with an SRAM model.
module tb_eram_arbiter;
    import eram_pkg::*;

    logic c25 = 1'b0;
    logic reset_n = 1'b0;
    always #5 c25 = ~c25;

    int checks = 0;
    int errors = 0;

    eram_arbiter_if #(.AW(15), .DW(8)) bus ();
    logic [14:0] address;
    logic [7:0]  datain;
    logic [7:0]  dataout = '0;
    logic        we;

    eram_arbiter_if #(.AW(15), .DW(8)) bus2 ();
    logic [14:0] address2;
    logic [7:0]  datain2;
    logic [7:0]  dataout2 = '0;
    logic        we2;

    logic [7:0] mem  [32768];
    logic [7:0] mem2 [32768];

    eram_arbiter u_dut (
        .c25     (c25),
        .reset_n (reset_n),
        .bus     (bus),
        .address (address),
        .datain  (datain),
        .we      (we),
        .dataout (dataout)
    );

    eram_arbiter #(.WR_CYCLES(1), .RD_WAIT(4)) u_dut2 (
        .c25     (c25),
        .reset_n (reset_n),
        .bus     (bus2),
        .address (address2),
        .datain  (datain2),
        .we      (we2),
        .dataout (dataout2)
    );

    // pin stage + SRAM: registered read data, write on strobe
    always @(posedge c25) begin
        dataout <= mem[address];
        if (we) mem[address] = datain;
    end

    always @(posedge c25) begin
        dataout2 <= mem2[address2];
        if (we2) mem2[address2] = datain2;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge c25);
    endtask

    logic [14:0] prev_addr = '0;
    always @(negedge c25) begin
        if (we) chk("we_addr_stable", 32'(address), 32'(prev_addr));
        prev_addr = address;
    end

    initial begin
        int n;
        int na, nb, ng, nr;
        int order [8];
        logic pa, pb;
        int arv;
        int wcnt;
        logic [3:0] wexp;

        for (int i = 0; i < 32768; i++) begin
            mem[i]  = 8'h00;
            mem2[i] = 8'h00;
        end
        mem[15'h1234]  = 8'hA5;
        for (int i = 0; i < 4; i++) mem[15'h100 + i] = 8'h40 + 8'(i);
        mem2[15'h0ABC] = 8'h3C;

        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        bus2.a_req = 0; bus2.a_we = 0; bus2.a_addr = '0;
        bus2.a_wdata = '0;
        bus2.b_req = 0; bus2.b_we = 0; bus2.b_addr = '0;
        bus2.b_wdata = '0;

        // reset values
        repeat (2) step();
        chk("rst_address", 32'(address), 0);
        chk("rst_datain", 32'(datain), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_a_ack", 32'(bus.a_ack), 0);
        chk("rst_b_ack", 32'(bus.b_ack), 0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("rst_b_rvalid", 32'(bus.b_rvalid), 0);
        chk("rst_a_rdata", 32'(bus.a_rdata), 0);
        chk("rst_b_rdata", 32'(bus.b_rdata), 0);
        reset_n = 1'b1;
        step();

        // A read of 0x1234
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 15'h1234;
        step();
        chk("rd_a_ack", 32'(bus.a_ack), 1);
        chk("rd_b_ack", 32'(bus.b_ack), 0);
        chk("rd_address", 32'(address), 32'h1234);
        bus.a_req = 0;
        step();
        chk("rd_a_ack_drop", 32'(bus.a_ack), 0);
        chk("rd_address_hold", 32'(address), 32'h1234);
        chk("rd_rvalid_early1", 32'(bus.a_rvalid), 0);
        step();
        chk("rd_rvalid_early2", 32'(bus.a_rvalid), 0);
        step();
        chk("rd_rvalid", 32'(bus.a_rvalid), 1);
        chk("rd_rdata", 32'(bus.a_rdata), 32'hA5);
        chk("rd_b_rvalid", 32'(bus.b_rvalid), 0);
        step();
        chk("rd_rvalid_pulse", 32'(bus.a_rvalid), 0);

        // B write of 0x5C to 0x7FFF
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 15'h7FFF;
        bus.b_wdata = 8'h5C;
        wexp = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) chk("wr_b_ack", 32'(bus.b_ack), 1);
            else chk("wr_b_ack_once", 32'(bus.b_ack), 0);
            bus.b_req = 0;
            chk("wr_we_seq", 32'(we), 32'(wexp[3-i]));
            chk("wr_address", 32'(address), 32'h7FFF);
            chk("wr_datain", 32'(datain), 32'h5C);
        end
        step();
        chk("wr_we_idle", 32'(we), 0);
        chk("wr_mem", 32'(mem[15'h7FFF]), 32'h5C);
        chk("wr_no_rvalid", 32'(bus.b_rvalid), 0);

        // both clients, 4 transactions each
        na = 0; nb = 0; ng = 0; nr = 0; pa = 0; pb = 0;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 15'h100;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 15'h200;
        bus.b_wdata = 8'h20;
        for (int cyc = 0; cyc < 200 && (ng < 8 || nr < 4); cyc++) begin
            step();
            chk("rr_ack_excl", 32'(bus.a_ack & bus.b_ack), 0);
            if (bus.a_ack) begin
                chk("rr_a_ack_pulse", 32'(pa), 0);
                if (ng < 8) order[ng] = 0;
                ng++; na++;
                if (na < 4) bus.a_addr = 15'h100 + 15'(na);
                else bus.a_req = 0;
            end
            if (bus.b_ack) begin
                chk("rr_b_ack_pulse", 32'(pb), 0);
                if (ng < 8) order[ng] = 1;
                ng++; nb++;
                if (nb < 4) begin
                    bus.b_addr  = 15'h200 + 15'(nb);
                    bus.b_wdata = 8'h20 + 8'(nb);
                end else begin
                    bus.b_req = 0;
                end
            end
            if (bus.a_rvalid) begin
                chk("rr_a_rdata", 32'(bus.a_rdata), 32'h40 + 32'(nr));
                nr++;
            end
            pa = bus.a_ack;
            pb = bus.b_ack;
        end
        chk("rr_a_count", 32'(na), 4);
        chk("rr_b_count", 32'(nb), 4);
        chk("rr_rd_count", 32'(nr), 4);
        for (int i = 0; i < 8; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
        repeat (6) step();
        for (int i = 0; i < 4; i++)
            chk("rr_b_mem", 32'(mem[15'h200 + i]), 32'h20 + 32'(i));

        // A writes 0x11 to 0, B reads 0 right behind it
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 15'h0;
        bus.a_wdata = 8'h11;
        step();
        chk("wb_a_ack", 32'(bus.a_ack), 1);
        bus.a_req = 0;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 15'h0;
        n = 0; arv = 0;
        while (!bus.b_ack && n < 20) begin
            step();
            n++;
        end
        chk("wb_b_ack_lat", 32'(n), 5);
        bus.b_req = 0;
        n = 0;
        while (!bus.b_rvalid && n < 20) begin
            step();
            n++;
            if (bus.a_rvalid) arv++;
        end
        chk("wb_b_rd_lat", 32'(n), 3);
        chk("wb_b_rdata", 32'(bus.b_rdata), 32'h11);
        chk("wb_a_rdata_kept", 32'(bus.a_rdata), 32'h43);
        chk("wb_no_a_rvalid", 32'(arv), 0);
        step();

        // async reset in the middle of the write pulse
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 15'h0555;
        bus.a_wdata = 8'h77;
        step();
        chk("ar_a_ack", 32'(bus.a_ack), 1);
        bus.a_req = 0;
        step();
        chk("ar_we_pulse", 32'(we), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_we_async", 32'(we), 0);
        chk("ar_address", 32'(address), 0);
        chk("ar_datain", 32'(datain), 0);
        chk("ar_a_ack_clr", 32'(bus.a_ack), 0);
        repeat (2) step();
        chk("ar_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("ar_b_rvalid", 32'(bus.b_rvalid), 0);
        chk("ar_a_rdata", 32'(bus.a_rdata), 0);
        chk("ar_b_rdata", 32'(bus.b_rdata), 0);
        reset_n = 1'b1;
        step();
        chk("ar_mem_untouched", 32'(mem[15'h0555]), 0);
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 15'h1234;
        step();
        chk("ar_rd_ack", 32'(bus.a_ack), 1);
        bus.a_req = 0;
        n = 0;
        while (!bus.a_rvalid && n < 20) begin
            step();
            n++;
        end
        chk("ar_rd_lat", 32'(n), 3);
        chk("ar_rd_rdata", 32'(bus.a_rdata), 32'hA5);

        // WR_CYCLES=1, RD_WAIT=4 build
        bus2.a_req = 1; bus2.a_we = 1; bus2.a_addr = 15'h0010;
        bus2.a_wdata = 8'h99;
        step();
        chk("p2_wr_ack", 32'(bus2.a_ack), 1);
        chk("p2_wr_setup_we", 32'(we2), 0);
        bus2.a_req = 0;
        wexp = 4'b0100;
        wcnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (we2) wcnt++;
            chk("p2_wr_we_seq", 32'(we2), 32'(wexp[2-i]));
        end
        chk("p2_wr_width", 32'(wcnt), 1);
        chk("p2_wr_mem", 32'(mem2[15'h0010]), 32'h99);
        bus2.a_req = 1; bus2.a_we = 0; bus2.a_addr = 15'h0ABC;
        step();
        chk("p2_rd_ack", 32'(bus2.a_ack), 1);
        bus2.a_req = 0;
        n = 0;
        while (!bus2.a_rvalid && n < 20) begin
            step();
            n++;
        end
        chk("p2_rd_lat", 32'(n), 5);
        chk("p2_rd_rdata", 32'(bus2.a_rdata), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
